// File: rtl/anti_theft_pkg.sv
// Shared definitions for the anti-theft sequencer: state encodings,
// parameter-register indices and power-on time values.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        S_DISARMED    = 3'd0,
        S_WAIT_OPEN   = 3'd1,
        S_WAIT_CLOSE  = 3'd2,
        S_ARM_DELAY   = 3'd3,
        S_ARMED       = 3'd4,
        S_TRIGGERED   = 3'd5,
        S_SOUND_ALARM = 3'd6,
        S_ALARM_HOLD  = 3'd7
    } state_e;

    localparam logic [1:0] P_ARM    = 2'd0;
    localparam logic [1:0] P_DRIVER = 2'd1;
    localparam logic [1:0] P_PASS   = 2'd2;
    localparam logic [1:0] P_ALARM  = 2'd3;

    localparam logic [3:0] DEFAULT_ARM    = 4'd6;
    localparam logic [3:0] DEFAULT_DRIVER = 4'd8;
    localparam logic [3:0] DEFAULT_PASS   = 4'd15;
    localparam logic [3:0] DEFAULT_ALARM  = 4'd10;

endpackage

// File: rtl/anti_theft_timer_if.sv
// Link between the sequencer and the shared countdown timer.
// Handshake: start_timer is a level; interval is stable while it is high; the
// timer answers with expired (may stay high) and a one-cycle two_hz_enable.
interface anti_theft_timer_if;
    logic [3:0] interval;
    logic       start_timer;
    logic       expired;
    logic       two_hz_enable;

    modport master (
        output interval,
        output start_timer,
        input  expired,
        input  two_hz_enable
    );

    modport slave (
        input  interval,
        input  start_timer,
        output expired,
        output two_hz_enable
    );
endinterface

// File: rtl/time_param_regs.sv
// Four 4-bit time parameters with one write port and a combinational read.
module time_param_regs
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] ARM_INIT    = DEFAULT_ARM,
    parameter logic [3:0] DRIVER_INIT = DEFAULT_DRIVER,
    parameter logic [3:0] PASS_INIT   = DEFAULT_PASS,
    parameter logic [3:0] ALARM_INIT  = DEFAULT_ALARM
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [3:0] wr_value,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_value
);

    logic [3:0] regs [4];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs[P_ARM]    <= ARM_INIT;
            regs[P_DRIVER] <= DRIVER_INIT;
            regs[P_PASS]   <= PASS_INIT;
            regs[P_ALARM]  <= ALARM_INIT;
        end else if (wr_en) begin
            regs[wr_sel] <= wr_value;
        end
    end

    assign rd_value = regs[rd_sel];

endmodule

// File: rtl/anti_theft_controller.sv
// Anti-theft sequencer: tracks ignition/door activity, requests countdowns
// from the shared timer and drives the siren and status LED.
module anti_theft_controller
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] T_ARM_DEFAULT    = DEFAULT_ARM,
    parameter logic [3:0] T_DRIVER_DEFAULT = DEFAULT_DRIVER,
    parameter logic [3:0] T_PASS_DEFAULT   = DEFAULT_PASS,
    parameter logic [3:0] T_ALARM_DEFAULT  = DEFAULT_ALARM
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ignition,
    input  logic                      door_driver,
    input  logic                      door_pass,
    input  logic                      reprogram,
    input  logic [1:0]                time_param_sel,
    input  logic [3:0]                time_value,
    anti_theft_timer_if.master        tmr,
    output logic                      siren,
    output logic                      status_led,
    output logic [2:0]                state_out
);

    state_e     state_q, state_d;
    logic [1:0] guard_q;
    logic       start_q;
    logic [3:0] interval_q;
    logic       siren_q, led_q, led_d;
    logic       load_en;
    logic [1:0] load_sel;
    logic [3:0] param_value;
    logic       any_door, expired_ok, entering, timed_d;

    time_param_regs #(
        .ARM_INIT    (T_ARM_DEFAULT),
        .DRIVER_INIT (T_DRIVER_DEFAULT),
        .PASS_INIT   (T_PASS_DEFAULT),
        .ALARM_INIT  (T_ALARM_DEFAULT)
    ) u_params (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (reprogram),
        .wr_sel   (time_param_sel),
        .wr_value (time_value),
        .rd_sel   (load_sel),
        .rd_value (param_value)
    );

    assign any_door = door_driver | door_pass;
    // A sticky expired left over from the previous countdown is ignored until
    // the timer has seen start_timer high for two cycles.
    assign expired_ok = tmr.expired && (guard_q >= 2'd2);

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        load_sel = P_ARM;
        if (reprogram) begin
            state_d = S_ARMED;
        end else if (ignition && state_q != S_DISARMED) begin
            state_d = S_DISARMED;
        end else begin
            case (state_q)
                S_DISARMED:   if (!ignition) state_d = S_WAIT_OPEN;
                S_WAIT_OPEN:  if (door_driver) state_d = S_WAIT_CLOSE;
                S_WAIT_CLOSE: if (!door_driver) begin
                    state_d = S_ARM_DELAY;
                    load_en = 1'b1;
                    load_sel = P_ARM;
                end
                S_ARM_DELAY: begin
                    if (any_door) state_d = S_WAIT_CLOSE;
                    else if (expired_ok) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (door_driver) begin
                        state_d = S_TRIGGERED;
                        load_en = 1'b1;
                        load_sel = P_DRIVER;
                    end else if (door_pass) begin
                        state_d = S_TRIGGERED;
                        load_en = 1'b1;
                        load_sel = P_PASS;
                    end
                end
                S_TRIGGERED:  if (expired_ok) state_d = S_SOUND_ALARM;
                S_SOUND_ALARM: if (!any_door) begin
                    state_d = S_ALARM_HOLD;
                    load_en = 1'b1;
                    load_sel = P_ALARM;
                end
                S_ALARM_HOLD: begin
                    if (any_door) state_d = S_SOUND_ALARM;
                    else if (expired_ok) state_d = S_ARMED;
                end
                default: state_d = S_ARMED;
            endcase
        end
    end

    // Reprogram counts as a fresh entry so the ARMED blink restarts dark.
    assign entering = (state_d != state_q) || reprogram;
    assign timed_d  = (state_d == S_ARM_DELAY) || (state_d == S_TRIGGERED) ||
                      (state_d == S_ALARM_HOLD);

    always_comb begin
        led_d = 1'b0;
        case (state_d)
            S_TRIGGERED, S_SOUND_ALARM, S_ALARM_HOLD: led_d = 1'b1;
            S_ARMED: led_d = entering ? 1'b0 : (led_q ^ tmr.two_hz_enable);
            default: led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_ARMED;
            guard_q    <= 2'd0;
            start_q    <= 1'b0;
            interval_q <= 4'd0;
            siren_q    <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Entry cycle holds start low so the timer sees a clean restart.
            start_q    <= timed_d && !entering;
            guard_q    <= start_q ? ((guard_q == 2'd3) ? 2'd3 : guard_q + 2'd1) : 2'd0;
            if (load_en) interval_q <= param_value;
            siren_q    <= (state_d == S_SOUND_ALARM) || (state_d == S_ALARM_HOLD);
            led_q      <= led_d;
        end
    end

    assign tmr.start_timer = start_q;
    assign tmr.interval    = interval_q;
    assign siren           = siren_q;
    assign status_led      = led_q;
    assign state_out       = state_q;

endmodule
